// File: rtl/int2fp_pkg.sv
// Shared constants and elaboration-time helpers for the integer-to-float pipeline.
package int2fp_pkg;

  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RTZ = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int out_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

endpackage

// File: rtl/i2f_lzc.sv
// Leading-zero counter built as a halving tree; an all-zero input returns W.
module i2f_lzc
  import int2fp_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]            i_data,
  output logic [clog2(W+1)-1:0]   o_cnt
);

  localparam int L  = clog2(W);
  localparam int P  = 1 << L;
  localparam int LW = L + 1;
  localparam int OW = clog2(W + 1);

  logic [P-1:0] w_pad;

  // Ones below the LSB leave non-zero counts untouched and make all-zero read as W.
  generate
    if (P > W) begin : g_pad
      assign w_pad = {i_data, {(P-W){1'b1}}};
    end else begin : g_nopad
      assign w_pad = i_data;
    end
  endgenerate

  genvar gi, gj;
  generate
    for (gi = 0; gi <= L; gi++) begin : g_lvl
      localparam int N = P >> gi;
      logic [N-1:0]    z_w;
      logic [N*LW-1:0] c_w;
      if (gi == 0) begin : g_leaf
        for (gj = 0; gj < N; gj++) begin : g_bit
          assign z_w[gj]           = ~w_pad[gj];
          assign c_w[gj*LW +: LW]  = {{(LW-1){1'b0}}, ~w_pad[gj]};
        end
      end else begin : g_node
        // Node gj covers the upper child 2gj+1 and the lower child 2gj.
        for (gj = 0; gj < N; gj++) begin : g_pair
          assign z_w[gj] = g_lvl[gi-1].z_w[2*gj+1] & g_lvl[gi-1].z_w[2*gj];
          assign c_w[gj*LW +: LW] = g_lvl[gi-1].z_w[2*gj+1]
            ? g_lvl[gi-1].c_w[(2*gj+1)*LW +: LW] + g_lvl[gi-1].c_w[(2*gj)*LW +: LW]
            : g_lvl[gi-1].c_w[(2*gj+1)*LW +: LW];
        end
      end
    end
  endgenerate

  logic w_unused;
  assign w_unused = &{1'b0, g_lvl[L].z_w, g_lvl[L].c_w};
  assign o_cnt    = g_lvl[L].c_w[OW-1:0];

endmodule

// File: rtl/int_to_float_pipe.sv
// Four-stage valid/ready integer-to-float converter with per-sample RNE/RTZ rounding.
// Define INT2FP_FLAGS_EN to add the out_inexact / out_overflow outputs.
module int_to_float_pipe
  import int2fp_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int SIGNED = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IN_W-1:0]                    in_data,
  input  logic                               in_rtz,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [out_width(EXP_W,MAN_W)-1:0]  out_data
`ifdef INT2FP_FLAGS_EN
  ,
  output logic                               out_inexact,
  output logic                               out_overflow
`endif
);

  localparam int OW   = out_width(EXP_W, MAN_W);
  localparam int LZW  = clog2(IN_W + 1);
  localparam int EW2  = EXP_W + 2;
  localparam int BIAS = exp_bias(EXP_W);
  localparam int FW   = (IN_W - 1 > MAN_W + 2) ? IN_W - 1 : MAN_W + 2;
  localparam logic [EW2-1:0] EXP_SAT = EW2'((1 << EXP_W) - 1);

  logic w_rdy1, w_rdy2, w_rdy3, w_rdy4;
  logic r_v1, r_v2, r_v3, r_v4;

  assign w_rdy4   = ~r_v4 | out_ready;
  assign w_rdy3   = ~r_v3 | w_rdy4;
  assign w_rdy2   = ~r_v2 | w_rdy3;
  assign w_rdy1   = ~r_v1 | w_rdy2;
  assign in_ready = w_rdy1;

  logic            w_sign;
  logic [IN_W-1:0] w_mag;
  assign w_sign = (SIGNED != 0) && in_data[IN_W-1];
  assign w_mag  = w_sign ? -in_data : in_data;

  logic            r1_sign, r1_rtz;
  logic [IN_W-1:0] r1_mag;

  logic [LZW-1:0]  w_lz;
  i2f_lzc #(.W(IN_W)) u_lzc (
    .i_data (r1_mag),
    .o_cnt  (w_lz)
  );

  logic            r2_sign, r2_rtz, r2_zero;
  logic [IN_W-1:0] r2_mag;
  logic [LZW-1:0]  r2_lz;

  logic [IN_W-1:0] w_norm;
  logic            w_unused;
  assign w_norm   = r2_mag << r2_lz;
  // The normalised MSB is always 1 for non-zero input, so only the bits below it are kept.
  assign w_unused = &{1'b0, w_norm[IN_W-1]};

  logic            r3_sign, r3_rtz, r3_zero;
  logic [IN_W-2:0] r3_frac;
  logic [EW2-1:0]  r3_exp;

  logic [FW-1:0]    w_frac;
  logic [MAN_W-1:0] w_man, w_man_rnd;
  logic             w_guard, w_sticky, w_inc, w_carry, w_ovf;
  logic [MAN_W:0]   w_man_sum;
  logic [EW2-1:0]   w_exp_b;
  logic [OW-1:0]    w_result;

  generate
    if (FW > IN_W - 1) begin : g_frac_pad
      assign w_frac = {r3_frac, {(FW-IN_W+1){1'b0}}};
    end else begin : g_frac_exact
      assign w_frac = r3_frac;
    end
  endgenerate

  // Narrow inputs pad with zeros here, so guard and sticky vanish and the result is exact.
  assign w_man     = w_frac[FW-1 -: MAN_W];
  assign w_guard   = w_frac[FW-1-MAN_W];
  assign w_sticky  = |w_frac[FW-2-MAN_W:0];
  assign w_inc     = (r3_rtz == RND_RNE) & w_guard & (w_sticky | w_man[0]);
  assign w_man_sum = {1'b0, w_man} + {{MAN_W{1'b0}}, w_inc};
  assign w_carry   = w_man_sum[MAN_W];
  assign w_man_rnd = w_carry ? '0 : w_man_sum[MAN_W-1:0];
  assign w_exp_b   = r3_exp + EW2'(BIAS) + {{(EW2-1){1'b0}}, w_carry};
  assign w_ovf     = ~r3_zero & (w_exp_b >= EXP_SAT);

  always_comb begin
    w_result = {r3_sign, w_exp_b[EXP_W-1:0], w_man_rnd};
    if (r3_zero)
      w_result = '0;
    else if (w_ovf && r3_rtz == RND_RTZ)
      w_result = {r3_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    else if (w_ovf)
      w_result = {r3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  logic [OW-1:0] r_out_data;
  assign out_valid = r_v4;
  assign out_data  = r_out_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
      r_v4       <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (w_rdy1) r_v1 <= in_valid;
      if (in_valid && w_rdy1) begin
        r1_sign <= w_sign;
        r1_mag  <= w_mag;
        r1_rtz  <= in_rtz;
      end
      if (w_rdy2) r_v2 <= r_v1;
      if (r_v1 && w_rdy2) begin
        r2_sign <= r1_sign;
        r2_mag  <= r1_mag;
        r2_lz   <= w_lz;
        r2_zero <= (r1_mag == '0);
        r2_rtz  <= r1_rtz;
      end
      if (w_rdy3) r_v3 <= r_v2;
      if (r_v2 && w_rdy3) begin
        r3_sign <= r2_sign;
        r3_frac <= w_norm[IN_W-2:0];
        r3_exp  <= EW2'(IN_W - 1) - EW2'(r2_lz);
        r3_zero <= r2_zero;
        r3_rtz  <= r2_rtz;
      end
      if (w_rdy4) r_v4 <= r_v3;
      if (r_v3 && w_rdy4) r_out_data <= w_result;
    end
  end

`ifdef INT2FP_FLAGS_EN
  logic r_inexact, r_overflow;
  assign out_inexact  = r_inexact;
  assign out_overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inexact  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (r_v3 && w_rdy4) begin
      r_inexact  <= w_guard | w_sticky;
      r_overflow <= w_ovf;
    end
  end
`endif

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Directed bench: default fp32 build, a 5/10 narrow-format build and an unsigned build.
module tb_int_to_float_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_rtz = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_data = '0;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic        in_ready_h, out_valid_h;
  logic [15:0] out_data_h;
  logic        in_ready_u, out_valid_u;
  logic [31:0] out_data_u;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  int_to_float_pipe #(.IN_W(32), .EXP_W(8), .MAN_W(23), .SIGNED(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_rtz(in_rtz), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  int_to_float_pipe #(.IN_W(32), .EXP_W(5), .MAN_W(10), .SIGNED(1)) u_dut_h (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h), .in_data(in_data),
    .in_rtz(in_rtz), .out_valid(out_valid_h), .out_ready(out_ready), .out_data(out_data_h)
  );

  int_to_float_pipe #(.IN_W(32), .EXP_W(8), .MAN_W(23), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
    .in_rtz(in_rtz), .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one sample, then count edges until the result shows up (bounded).
  task automatic send(input logic [31:0] d, input logic rtz, output int lat);
    in_valid = 1'b1;
    in_data  = d;
    in_rtz   = rtz;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // sel: 0 = default fp32, 1 = 5/10 format, 2 = unsigned fp32
  task automatic run_vec(input string tag, input logic [31:0] d, input logic rtz,
                         input int sel, input logic [31:0] exp);
    int lat;
    logic [31:0] got;
    send(d, rtz, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'd4);
    if (sel == 0)      got = out_data;
    else if (sel == 1) got = {16'h0, out_data_h};
    else               got = out_data_u;
    check_eq(tag, got, exp);
    $display("vec %s in=%h rtz=%0d out=%h exp=%h", tag, d, rtz, got, exp);
  endtask

  logic [31:0] bp_exp [0:7];
  logic [31:0] got_q [$];

  initial begin
    bp_exp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", out_data, 32'd0);
    check_eq("rst_data_h", {16'h0, out_data_h}, 32'd0);
    rst = 1'b1;
    check_eq("rst_rel_rdy", 32'(in_ready), 32'd1);

    run_vec("one",      32'h00000001, 1'b0, 0, 32'h3F800000);
    run_vec("neg_one",  32'hFFFFFFFF, 1'b0, 0, 32'hBF800000);
    run_vec("zero",     32'h00000000, 1'b0, 0, 32'h00000000);
    run_vec("zero_rtz", 32'h00000000, 1'b1, 0, 32'h00000000);
    run_vec("min_int",  32'h80000000, 1'b0, 0, 32'hCF000000);
    run_vec("max_rne",  32'h7FFFFFFF, 1'b0, 0, 32'h4F000000);
    run_vec("max_rtz",  32'h7FFFFFFF, 1'b1, 0, 32'h4EFFFFFF);
    run_vec("tie_even", 32'h01000001, 1'b0, 0, 32'h4B800000);
    run_vec("tie_up",   32'h01000003, 1'b0, 0, 32'h4B800002);
    run_vec("h_ovf_rne",  32'd65520,     1'b0, 1, 32'h00007C00);
    run_vec("h_ovf_rtz",  32'd65520,     1'b1, 1, 32'h00007BFF);
    run_vec("h_novf_neg", 32'hFFFF0010,  1'b0, 1, 32'h0000FC00);
    run_vec("h_neg_one",  32'hFFFFFFFF,  1'b0, 1, 32'h0000BC00);
    run_vec("u_max",      32'hFFFFFFFF,  1'b0, 2, 32'h4F800000);
    run_vec("u_msb",      32'h80000000,  1'b0, 2, 32'h4F000000);

    // Backpressure: samples 1..8 back-to-back, out_ready low in cycles 3..9.
    begin
      int sent, irdy_lo;
      sent = 0;
      irdy_lo = 0;
      got_q.delete();
      @(posedge clk); #1;
      for (int c = 0; c < 40; c++) begin
        out_ready = !(c >= 3 && c <= 9);
        in_valid  = (sent < 8);
        in_data   = 32'(sent + 1);
        in_rtz    = 1'b0;
        #1;
        if (!in_ready) irdy_lo++;
        if (c >= 4 && c <= 9) begin
          check_eq($sformatf("bp_hold_v%0d", c), 32'(out_valid), 32'd1);
          check_eq($sformatf("bp_hold_d%0d", c), out_data, 32'h3F800000);
        end
        if (in_valid && in_ready) sent++;
        if (out_valid && out_ready) got_q.push_back(out_data);
        @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check_eq("bp_inrdy_lo", 32'(irdy_lo), 32'd6);
      check_eq("bp_count", 32'(got_q.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
        logic [31:0] g;
        g = (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF;
        check_eq($sformatf("bp_seq%0d", i), g, bp_exp[i]);
        $display("bp result %0d out=%h exp=%h", i, g, bp_exp[i]);
      end
    end

    // Reset with three samples in flight.
    begin
      int seen;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        in_valid = 1'b1;
        in_data  = 32'(k + 10);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("rst_mid_v", 32'(out_valid), 32'd0);
      check_eq("rst_mid_d", out_data, 32'd0);
      rst = 1'b1;
      #1;
      check_eq("rst_mid_rdy", 32'(in_ready), 32'd1);
      seen = 0;
      repeat (10) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check_eq("rst_stale", 32'(seen), 32'd0);
      $display("reset mid-flight stale_results=%0d", seen);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
